// File: rtl/tl_pkg.sv
// Shared definitions for the tail light sequencer: mode encodings, turn
// pattern constants and the request priority function.
package tl_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE   = 3'b000,
    MODE_LEFT   = 3'b001,
    MODE_RIGHT  = 3'b010,
    MODE_LBREAK = 3'b011,
    MODE_RBREAK = 3'b100,
    MODE_BREAK  = 3'b101,
    MODE_HAZARD = 3'b110
  } mode_t;

  localparam logic [2:0] TURN_S0   = 3'b001;
  localparam logic [2:0] TURN_S1   = 3'b011;
  localparam logic [2:0] TURN_S2   = 3'b111;
  localparam logic [2:0] TURN_S3   = 3'b000;
  localparam logic [2:0] LAMPS_OFF = 3'b000;
  localparam logic [2:0] LAMPS_ON  = 3'b111;

  function automatic logic [2:0] turn_pattern(input logic [1:0] step);
    logic [2:0] pat;
    case (step)
      2'd0:    pat = TURN_S0;
      2'd1:    pat = TURN_S1;
      2'd2:    pat = TURN_S2;
      default: pat = TURN_S3;
    endcase
    return pat;
  endfunction

  // Left+right together is treated as a hazard request, above brake.
  function automatic mode_t request_mode(input logic left, input logic right,
                                         input logic brake, input logic hazard);
    mode_t m;
    if (hazard || (left && right)) m = MODE_HAZARD;
    else if (brake && left)        m = MODE_LBREAK;
    else if (brake && right)       m = MODE_RBREAK;
    else if (brake)                m = MODE_BREAK;
    else if (left)                 m = MODE_LEFT;
    else if (right)                m = MODE_RIGHT;
    else                           m = MODE_IDLE;
    return m;
  endfunction

endpackage

// File: rtl/tail_light_sequencer_if.sv
// Switch inputs and lamp/status outputs of the tail light sequencer.
// Level signals only, no handshake: switches are sampled every rising edge.
interface tail_light_sequencer_if;
  logic       left;
  logic       right;
  logic       brake;
  logic       hazard;
  logic [2:0] lamps_l;
  logic [2:0] lamps_r;
  logic [2:0] mode;
  logic [1:0] step;

  modport master (
    output left, right, brake, hazard,
    input  lamps_l, lamps_r, mode, step
  );

  modport slave (
    input  left, right, brake, hazard,
    output lamps_l, lamps_r, mode, step
  );
endinterface

// File: rtl/tl_mode_reg.sv
// Mode register: holds the current lamp mode, resets asynchronously to IDLE.
module tl_mode_reg
  import tl_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  load,
  input  mode_t d,
  output mode_t q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    q <= MODE_IDLE;
    else if (load) q <= d;
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail light sequencer top: request priority, prescaler, step counter and
// combinational lamp decode around the tl_mode_reg mode register.
module tail_light_sequencer
  import tl_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input logic                  clock,
  input logic                  reset,
  tail_light_sequencer_if.slave bus
);

  localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

  mode_t       req;
  mode_t       mode_q;
  logic [15:0] presc_q;
  logic [1:0]  step_q;
  logic        tick;
  logic        mode_load;
  logic [2:0]  lamps_l;
  logic [2:0]  lamps_r;

  always_comb req = request_mode(bus.left, bus.right, bus.brake, bus.hazard);

  assign tick = (presc_q == PRESC_LAST);

  // Leaving IDLE is immediate; any other mode change waits for a tick.
  always_comb begin
    mode_load = 1'b0;
    if (mode_q == MODE_IDLE) mode_load = (req != MODE_IDLE);
    else if (tick)           mode_load = (req != mode_q);
  end

  tl_mode_reg u_mode_reg (
    .clock (clock),
    .reset (reset),
    .load  (mode_load),
    .d     (req),
    .q     (mode_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      if (mode_q == MODE_IDLE || tick) presc_q <= '0;
      else                             presc_q <= presc_q + 16'd1;

      if (mode_load)                             step_q <= 2'd0;
      else if (mode_q != MODE_IDLE && tick)      step_q <= step_q + 2'd1;
    end
  end

  always_comb begin
    lamps_l = LAMPS_OFF;
    lamps_r = LAMPS_OFF;
    unique case (mode_q)
      MODE_LEFT:   lamps_l = turn_pattern(step_q);
      MODE_RIGHT:  lamps_r = turn_pattern(step_q);
      MODE_LBREAK: begin
        lamps_l = turn_pattern(step_q);
        lamps_r = LAMPS_ON;
      end
      MODE_RBREAK: begin
        lamps_l = LAMPS_ON;
        lamps_r = turn_pattern(step_q);
      end
      MODE_BREAK: begin
        lamps_l = LAMPS_ON;
        lamps_r = LAMPS_ON;
      end
      MODE_HAZARD: begin
        lamps_l = step_q[0] ? LAMPS_OFF : LAMPS_ON;
        lamps_r = step_q[0] ? LAMPS_OFF : LAMPS_ON;
      end
      default: begin
        lamps_l = LAMPS_OFF;
        lamps_r = LAMPS_OFF;
      end
    endcase
  end

  assign bus.lamps_l = lamps_l;
  assign bus.lamps_r = lamps_r;
  assign bus.mode    = mode_q;
  assign bus.step    = step_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed bench for tail_light_sequencer with TICK_DIV = 4; expected values
// are hand-computed per step of the sequence below.
module tb_tail_light_sequencer;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  tail_light_sequencer_if bus ();

  tail_light_sequencer #(.TICK_DIV(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic expect_state(input string tag, input logic [2:0] m, input logic [1:0] s,
                              input logic [2:0] l, input logic [2:0] r);
    check({tag, "_mode"},    bus.mode,          m);
    check({tag, "_step"},    {1'b0, bus.step},  {1'b0, s});
    check({tag, "_lamps_l"}, bus.lamps_l,       l);
    check({tag, "_lamps_r"}, bus.lamps_r,       r);
  endtask

  task automatic set_in(input logic l, input logic r, input logic b, input logic h);
    bus.left   = l;
    bus.right  = r;
    bus.brake  = b;
    bus.hazard = h;
  endtask

  initial begin
    logic [2:0] turn_tbl [4];
    turn_tbl[0] = 3'b001;
    turn_tbl[1] = 3'b011;
    turn_tbl[2] = 3'b111;
    turn_tbl[3] = 3'b000;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    set_in(0, 0, 0, 0);

    // Reset held low, then released mid-cycle; 20 idle cycles.
    #2;
    expect_state("reset", 3'b000, 2'd0, 3'b000, 3'b000);
    cyc(2);
    expect_state("reset_hold", 3'b000, 2'd0, 3'b000, 3'b000);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      expect_state("idle", 3'b000, 2'd0, 3'b000, 3'b000);
    end

    // Left from IDLE: first edge loads, then 4 cycles per step.
    set_in(1, 0, 0, 0);
    cyc(1);
    expect_state("left_load", 3'b001, 2'd0, 3'b001, 3'b000);
    for (int k = 1; k <= 4; k++) begin
      cyc(3);
      expect_state("left_hold", 3'b001, 2'((k - 1) % 4), turn_tbl[(k - 1) % 4], 3'b000);
      cyc(1);
      expect_state("left_step", 3'b001, 2'(k % 4), turn_tbl[k % 4], 3'b000);
    end

    // Right pulsed for 2 cycles between ticks: no effect on LEFT.
    set_in(1, 1, 0, 0);
    cyc(2);
    expect_state("glitch_mid", 3'b001, 2'd0, 3'b001, 3'b000);
    set_in(1, 0, 0, 0);
    cyc(2);
    expect_state("glitch_after", 3'b001, 2'd1, 3'b011, 3'b000);

    // Left + brake: change waits for the tick, then LBREAK from step 0.
    set_in(1, 0, 1, 0);
    cyc(3);
    expect_state("lbrk_wait", 3'b001, 2'd1, 3'b011, 3'b000);
    cyc(1);
    expect_state("lbrk_load", 3'b011, 2'd0, 3'b001, 3'b111);
    cyc(4);
    expect_state("lbrk_s1", 3'b011, 2'd1, 3'b011, 3'b111);
    cyc(4);
    expect_state("lbrk_s2", 3'b011, 2'd2, 3'b111, 3'b111);
    cyc(4);
    expect_state("lbrk_s3", 3'b011, 2'd3, 3'b000, 3'b111);
    set_in(1, 0, 0, 0);
    cyc(4);
    expect_state("brk_release", 3'b001, 2'd0, 3'b001, 3'b000);

    // Left + right -> HAZARD; adding brake keeps HAZARD.
    set_in(1, 1, 0, 0);
    cyc(4);
    expect_state("haz_s0", 3'b110, 2'd0, 3'b111, 3'b111);
    cyc(4);
    expect_state("haz_s1", 3'b110, 2'd1, 3'b000, 3'b000);
    set_in(1, 1, 1, 0);
    cyc(4);
    expect_state("haz_brk_s2", 3'b110, 2'd2, 3'b111, 3'b111);
    cyc(4);
    expect_state("haz_brk_s3", 3'b110, 2'd3, 3'b000, 3'b000);
    set_in(0, 0, 0, 0);
    cyc(4);
    expect_state("haz_to_idle", 3'b000, 2'd0, 3'b000, 3'b000);

    // Right held 7 cycles, reset pulsed at step 1.
    set_in(0, 1, 0, 0);
    cyc(1);
    expect_state("right_load", 3'b010, 2'd0, 3'b000, 3'b001);
    cyc(4);
    expect_state("right_s1", 3'b010, 2'd1, 3'b000, 3'b011);
    cyc(2);
    reset = 1'b0;
    #1;
    expect_state("async_rst", 3'b000, 2'd0, 3'b000, 3'b000);
    cyc(1);
    expect_state("rst_held", 3'b000, 2'd0, 3'b000, 3'b000);
    reset = 1'b1;
    cyc(1);
    expect_state("post_rst_load", 3'b010, 2'd0, 3'b000, 3'b001);
    cyc(3);
    expect_state("post_rst_hold", 3'b010, 2'd0, 3'b000, 3'b001);
    cyc(1);
    expect_state("post_rst_s1", 3'b010, 2'd1, 3'b000, 3'b011);
    set_in(0, 0, 0, 0);
    cyc(4);
    expect_state("right_to_idle", 3'b000, 2'd0, 3'b000, 3'b000);

    // Brake alone, then brake + right -> RBREAK.
    set_in(0, 0, 1, 0);
    cyc(1);
    expect_state("brake_load", 3'b101, 2'd0, 3'b111, 3'b111);
    set_in(0, 1, 1, 0);
    cyc(4);
    expect_state("rbrk_load", 3'b100, 2'd0, 3'b111, 3'b001);
    cyc(4);
    expect_state("rbrk_s1", 3'b100, 2'd1, 3'b111, 3'b011);
    set_in(0, 0, 0, 0);
    cyc(4);
    expect_state("rbrk_to_idle", 3'b000, 2'd0, 3'b000, 3'b000);

    // Hazard switch outranks left.
    set_in(0, 0, 0, 1);
    cyc(1);
    expect_state("hzsw_load", 3'b110, 2'd0, 3'b111, 3'b111);
    set_in(1, 0, 0, 1);
    cyc(4);
    expect_state("hzsw_left", 3'b110, 2'd1, 3'b000, 3'b000);
    set_in(0, 0, 0, 0);
    cyc(4);
    expect_state("hzsw_idle", 3'b000, 2'd0, 3'b000, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tail_light_sequencer.md
TAIL_LIGHT_SEQUENCER -- requirements
Module: tail_light_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 4, clock cycles per animation step, legal range 2..65535.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 left  input  1  left turn switch level, synchronous to clock.
REQ-005 right  input  1  right turn switch level, synchronous to clock.
REQ-006 brake  input  1  brake pedal level, synchronous to clock.
REQ-007 hazard  input  1  hazard switch level, synchronous to clock.
REQ-008 lamps_l  output  3  left lamps; bit0 innermost, bit2 outermost; 1 = lit.
REQ-009 lamps_r  output  3  right lamps; bit0 innermost, bit2 outermost; 1 = lit.
REQ-010 mode  output  3  current mode: IDLE=000, LEFT=001, RIGHT=010, LBREAK=011, RBREAK=100, BREAK=101, HAZARD=110; 111 is never produced.
REQ-011 step  output  2  current animation step, 0..3.

Function
REQ-012 The requested mode SHALL be computed every cycle by fixed priority: hazard or (left and right) -> HAZARD; brake and left -> LBREAK; brake and right -> RBREAK; brake -> BREAK; left -> LEFT; right -> RIGHT; otherwise IDLE.
REQ-013 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick is true in any cycle where prescaler == TICK_DIV-1.
REQ-014 While mode == IDLE, the prescaler SHALL be held at 0. If the requested mode is not IDLE, the next edge SHALL load mode <= requested mode and step <= 0, with no wait for tick.
REQ-015 While mode != IDLE, mode SHALL change only on a tick edge. A tick edge with requested mode != mode SHALL load the requested mode (including IDLE) and step <= 0.
REQ-016 A tick edge with requested mode == mode SHALL advance step by 1, wrapping 3 -> 0.
REQ-017 Requests that are asserted and removed between two ticks SHALL have no effect.
REQ-018 The turn pattern SHALL be indexed by step: 0 -> 001, 1 -> 011, 2 -> 111, 3 -> 000.
REQ-019 Lamp decode SHALL be combinational from mode and step, as follows:
- IDLE: both 000.
- LEFT: lamps_l = turn pattern, lamps_r = 000.
- RIGHT: lamps_r = turn pattern, lamps_l = 000.
- LBREAK: lamps_l = turn pattern, lamps_r = 111.
- RBREAK: lamps_r = turn pattern, lamps_l = 111.
- BREAK: both 111.
- HAZARD: both 111 when step is even, both 000 when step is odd.
REQ-020 With a request held constant and non-IDLE, each step SHALL last exactly TICK_DIV cycles.

Reset
REQ-021 Asserting reset SHALL immediately force mode = IDLE, step = 0 and prescaler = 0, so lamps_l = lamps_r = 000, regardless of clock.
REQ-022 Reset asserted in the middle of a sequence SHALL discard that sequence. After deassertion the first rising edge SHALL apply REQ-014 as from IDLE.

Structure
REQ-023 Mode encodings, TURN pattern constants and the mode width SHALL live in shared package tl_pkg.
REQ-024 The mode register SHALL be sub-module tl_mode_reg, a 3-bit register with asynchronous active-low reset to IDLE and a load enable. Priority logic, prescaler, step counter and lamp decode stay in the top module.

Verification (TICK_DIV = 4)
REQ-025 Reset low, then high, all inputs 0 for 20 cycles -> mode = 000, lamps_l = lamps_r = 000 throughout.
REQ-026 left held from IDLE:
- first edge -> mode = 001, lamps_l = 001.
- lamps_l then 011, 111, 000, 001 at 4-cycle intervals.
- lamps_r = 000 throughout.
REQ-027 left and brake held -> mode = 011, lamps_r = 111 constant, lamps_l cycles 001/011/111/000. Releasing brake -> mode = 001 at the next tick edge, step = 0.
REQ-028 left and right held -> mode = 110, both outputs alternate 111 and 000 every 4 cycles. Adding brake causes no mode change (priority check).
REQ-029 right held for 7 cycles, reset pulsed low at step 1 -> lamps_r = 000 immediately. After deassertion, the first edge gives mode = 010, step = 0.
REQ-030 From LEFT, right pulsed for 2 cycles between ticks -> mode stays 001 and the step sequence is unbroken.
